// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and read-owner encoding for the mips32 memory path.
package mips_pkg;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_IF   = 2'b01,
      OWN_DM   = 2'b10
   } owner_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: 4-bit saturating count of consecutive denied fetch cycles.
module arb_starve_ctr #(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_at_max
);
   logic [3:0] r_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_inc && r_cnt != 4'(MAX)) r_cnt <= r_cnt + 4'd1;
   assign o_at_max = r_cnt == 4'(MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port sync RAM between fetch and data ports,
// data first, with a starvation override that forces a fetch grant.
module mem_port_arbiter import mips_pkg::*; #(
   parameter int ADDR_W   = mips_pkg::ADDR_W,
   parameter int DATA_W   = mips_pkg::DATA_W,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_q
);
   logic              w_at_max;
   owner_t            r_owner;
   logic [DATA_W-1:0] r_if_data;
   logic [DATA_W-1:0] r_dm_data;

   arb_starve_ctr #(.MAX(MAX_WAIT)) u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_inc    (if_stall),
      .i_clr    (if_gnt | ~if_req),
      .o_at_max (w_at_max)
   );

   assign if_gnt    = if_req & (w_at_max | ~dm_req);
   assign dm_gnt    = dm_req & ~if_gnt;
   assign if_stall  = if_req & ~if_gnt;
   assign ram_addr  = dm_gnt ? dm_addr : if_addr;
   assign ram_we    = dm_gnt & dm_we;
   assign ram_wdata = dm_wdata;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_owner   <= OWN_NONE;
         r_if_data <= '0;
         r_dm_data <= '0;
      end else begin
         r_owner <= if_gnt ? OWN_IF : (dm_gnt & ~dm_we) ? OWN_DM : OWN_NONE;
         if (r_owner == OWN_IF) r_if_data <= ram_q;
         if (r_owner == OWN_DM) r_dm_data <= ram_q;
      end

   // the owner sees ram_q live in its response cycle; the other port keeps its last word
   assign if_rvalid = r_owner == OWN_IF;
   assign dm_rvalid = r_owner == OWN_DM;
   assign if_rdata  = if_rvalid ? ram_q : r_if_data;
   assign dm_rdata  = dm_rvalid ? ram_q : r_dm_data;
endmodule
